ps2_display_ctrl: RTL and testbench

- Sequences the 4-digit 7-segment hex display path for the PS/2 keyboard controller.
- Takes received scan-code bytes from the PS/2 receiver and assembles complete make/break sequences (single byte, E0-, F0-, E0 F0-prefixed).
- Drives the display decoder with a 16-bit word and an error flag.
- Error indication is held for a fixed time; stalled prefixes are aborted by timeout.

---
 rtl/ps2_display_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_ps2_display_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_display_ctrl.sv
// ps2_display_ctrl
// Assembles PS/2 scan-code bytes into complete make/break sequences and
// drives the 4-digit hex display word plus an error flag.
//
// Ports:
//   clk           system clock, rising edge
//   rst_n         asynchronous active-low reset
//   code_valid    one-cycle strobe qualifying code / code_err
//   code          received scan-code byte
//   code_err      parity/frame error for this byte
//   clear         synchronous request: blank display, drop sequence, end error
//   display_data  16-bit word to the display decoder (digit 3 = [15:12])
//   display_err   error flag to the display decoder
//   key_event     one-cycle pulse when display_data takes a completed sequence
//
// Handshake: code_valid is a single-cycle strobe with no back-pressure; every
// strobe is consumed on the edge that samples it. All outputs are registers,
// so results appear one cycle after the strobe.
//
// FSM state is held in the named enum register 'state' (IDLE/GOT_E0/GOT_F0)
// and the informational 'ext' flag, both probeable by hierarchical reference.

module ps2_display_ctrl #(
    parameter int ERR_HOLD_CYCLES = 50_000_000,
    parameter int TIMEOUT_CYCLES  = 2_500_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        code_valid,
    input  logic [7:0]  code,
    input  logic        code_err,
    input  logic        clear,
    output logic [15:0] display_data,
    output logic        display_err,
    output logic        key_event
);

    localparam int HW = $clog2(ERR_HOLD_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(ERR_HOLD_CYCLES);
    localparam logic [TW-1:0] TO_LOAD   = TW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GOT_E0 = 2'd1,
        GOT_F0 = 2'd2
    } state_t;

    state_t        state;
    logic          ext;
    logic [TW-1:0] to_cnt;
    logic [HW-1:0] hold_cnt;

    state_t        nxt_state;
    logic          nxt_ext;
    logic          raise_err;
    logic          complete;
    logic [15:0]   comp_word;
    logic          to_load;
    logic          is_e0;
    logic          is_f0;

    assign is_e0 = (code == 8'hE0);
    assign is_f0 = (code == 8'hF0);

    // Sequence decoding. A strobe in the cycle the timeout counter is at its
    // last count is processed normally; the timeout only fires without one.
    always_comb begin
        nxt_state = state;
        nxt_ext   = ext;
        raise_err = 1'b0;
        complete  = 1'b0;
        comp_word = display_data;
        to_load   = 1'b0;
        case (state)
            IDLE: begin
                if (code_valid) begin
                    if (code_err) begin
                        raise_err = 1'b1;
                    end else if (is_e0) begin
                        nxt_state = GOT_E0;
                        to_load   = 1'b1;
                    end else if (is_f0) begin
                        nxt_state = GOT_F0;
                        nxt_ext   = 1'b0;
                        to_load   = 1'b1;
                    end else begin
                        complete  = 1'b1;
                        comp_word = {8'h00, code};
                    end
                end
            end
            GOT_E0: begin
                if (code_valid) begin
                    if (code_err) begin
                        raise_err = 1'b1;
                        nxt_state = IDLE;
                    end else if (is_e0) begin
                        to_load = 1'b1;
                    end else if (is_f0) begin
                        nxt_state = GOT_F0;
                        nxt_ext   = 1'b1;
                        to_load   = 1'b1;
                    end else begin
                        complete  = 1'b1;
                        comp_word = {8'hE0, code};
                        nxt_state = IDLE;
                    end
                end else if (to_cnt <= TW'(1)) begin
                    raise_err = 1'b1;
                    nxt_state = IDLE;
                end
            end
            GOT_F0: begin
                if (code_valid) begin
                    nxt_state = IDLE;
                    if (code_err || is_e0 || is_f0) begin
                        raise_err = 1'b1;
                    end else begin
                        // E0 F0 b also displays F0b; ext is not shown.
                        complete  = 1'b1;
                        comp_word = {8'hF0, code};
                    end
                end else if (to_cnt <= TW'(1)) begin
                    raise_err = 1'b1;
                    nxt_state = IDLE;
                end
            end
            default: begin
                nxt_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            ext          <= 1'b0;
            to_cnt       <= '0;
            hold_cnt     <= '0;
            display_data <= 16'h0000;
            display_err  <= 1'b0;
            key_event    <= 1'b0;
        end else if (clear) begin
            // clear beats a coincident strobe: the byte is dropped.
            state        <= IDLE;
            ext          <= 1'b0;
            to_cnt       <= '0;
            hold_cnt     <= '0;
            display_data <= 16'h0000;
            display_err  <= 1'b0;
            key_event    <= 1'b0;
        end else begin
            state     <= nxt_state;
            ext       <= nxt_ext;
            key_event <= complete;
            if (complete) begin
                display_data <= comp_word;
            end

            if (to_load) begin
                to_cnt <= TO_LOAD;
            end else if (nxt_state == IDLE) begin
                to_cnt <= '0;
            end else if (to_cnt != '0) begin
                to_cnt <= to_cnt - TW'(1);
            end

            // A new error retriggers the hold; the flag drops on the edge
            // where the hold count runs out.
            if (raise_err) begin
                hold_cnt    <= HOLD_LOAD;
                display_err <= 1'b1;
            end else if (hold_cnt != '0) begin
                hold_cnt <= hold_cnt - HW'(1);
                if (hold_cnt == HW'(1)) begin
                    display_err <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_display_ctrl.sv
// Testbench for ps2_display_ctrl: directed scenarios followed by random
// stimulus, checked against a byte-list reference model via expectation
// queues that a separate monitor drains.

module tb_ps2_display_ctrl;

    localparam int H = 10;
    localparam int T = 8;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        code_valid = 1'b0;
    logic [7:0]  code = 8'h00;
    logic        code_err = 1'b0;
    logic        clear = 1'b0;
    logic [15:0] display_data;
    logic        display_err;
    logic        key_event;

    always #5 clk = ~clk;

    ps2_display_ctrl #(
        .ERR_HOLD_CYCLES(H),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .code_valid  (code_valid),
        .code        (code),
        .code_err    (code_err),
        .clear       (clear),
        .display_data(display_data),
        .display_err (display_err),
        .key_event   (key_event)
    );

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int failures = 0;
    logic [15:0] exp_q[$];      // expected words, one per key_event
    logic [17:0] st_q[$];       // expected {key_event, display_err, display_data} per cycle
    bit in_reset = 1'b1;

    // reference model: pending prefix bytes plus absolute-cycle deadlines
    logic [7:0]  pend[$];
    int          deadline = 0;
    int          err_end = 0;
    logic [15:0] m_data = 16'h0000;
    int          cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic m_error();
        pend.delete();
        err_end = cyc + H;
    endtask

    // ---------------- driver ----------------
    task automatic drive(input logic v, input logic [7:0] b, input logic e, input logic c);
        logic kev;
        kev = 1'b0;
        @(negedge clk);
        code_valid = v;
        code       = b;
        code_err   = e;
        clear      = c;
        if (c) begin
            pend.delete();
            m_data  = 16'h0000;
            err_end = 0;
        end else if (v) begin
            if (e) begin
                m_error();
            end else if (pend.size() == 0) begin
                if (b == 8'hE0 || b == 8'hF0) begin
                    pend.push_back(b);
                    deadline = cyc + T;
                end else begin
                    kev = 1'b1;
                    m_data = {8'h00, b};
                end
            end else if (pend[pend.size()-1] == 8'hE0) begin
                if (b == 8'hE0) begin
                    deadline = cyc + T;
                end else if (b == 8'hF0) begin
                    pend.push_back(b);
                    deadline = cyc + T;
                end else begin
                    kev = 1'b1;
                    m_data = {8'hE0, b};
                    pend.delete();
                end
            end else begin
                if (b == 8'hE0 || b == 8'hF0) begin
                    m_error();
                end else begin
                    kev = 1'b1;
                    m_data = {8'hF0, b};
                    pend.delete();
                end
            end
        end else if (pend.size() != 0 && cyc == deadline) begin
            m_error();
        end
        if (kev) exp_q.push_back(m_data);
        st_q.push_back({kev, (cyc < err_end), m_data});
        cyc++;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic send(input logic [7:0] b);
        drive(1'b1, b, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        in_reset   = 1'b1;
        code_valid = 1'b0;
        code_err   = 1'b0;
        clear      = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_data", 32'(display_data), 32'h0);
        chk("async_rst_err", 32'(display_err), 32'h0);
        chk("async_rst_key", 32'(key_event), 32'h0);
        pend.delete();
        m_data  = 16'h0000;
        err_end = 0;
        repeat (2) @(negedge clk);
        rst_n    = 1'b1;
        in_reset = 1'b0;
    endtask

    // ---------------- monitor ----------------
    logic [17:0] st;
    always begin
        @(posedge clk);
        #1;
        if (!in_reset && st_q.size() > 0) begin
            st = st_q.pop_front();
            chk("key_event", 32'(key_event), 32'(st[17]));
            chk("display_err", 32'(display_err), 32'(st[16]));
            chk("display_data", 32'(display_data), 32'(st[15:0]));
            if (key_event) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_event", 32'(display_data), 32'hFFFF_FFFF);
                end else begin
                    chk("event_word", 32'(display_data), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] rb;
        repeat (3) @(negedge clk);
        chk("reset_data", 32'(display_data), 32'h0);
        chk("reset_err", 32'(display_err), 32'h0);
        chk("reset_key", 32'(key_event), 32'h0);
        rst_n    = 1'b1;
        in_reset = 1'b0;

        // single make code
        send(8'h1C); idle(2);
        // break, extended make, extended break
        send(8'hF0); send(8'h1C); idle(1);
        send(8'hE0); send(8'h75); idle(1);
        send(8'hE0); send(8'hF0); send(8'h75); idle(2);
        // error hold with retrigger at +5
        drive(1'b1, 8'h1C, 1'b1, 1'b0); idle(4);
        drive(1'b1, 8'h33, 1'b1, 1'b0); idle(H + 3);
        // timeout after E0, then a plain byte
        send(8'hE0); idle(T + 3); send(8'h1C); idle(2);
        // byte on the last allowed cycle, then F0 F0 protocol error
        send(8'hE0); idle(T - 1); send(8'h12); idle(1);
        send(8'hF0); send(8'hF0); idle(3);
        // clear with coincident byte during error hold
        drive(1'b1, 8'h55, 1'b1, 1'b0); idle(2);
        drive(1'b1, 8'h1C, 1'b0, 1'b1); idle(2);
        // reset in the middle of a sequence
        send(8'hE0); send(8'hF0);
        do_reset();
        send(8'h1C); idle(2);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 3))
                0:       rb = 8'hE0;
                1:       rb = 8'hF0;
                default: rb = 8'($urandom_range(0, 255));
            endcase
            if ($urandom_range(0, 14) == 0) begin
                idle($urandom_range(1, T + 3));
            end else begin
                drive(($urandom_range(0, 2) != 0), rb,
                      ($urandom_range(0, 19) == 0),
                      ($urandom_range(0, 49) == 0));
            end
        end

        idle(H + 2);
        @(negedge clk);
        chk("status_q_drained", 32'(st_q.size()), 32'h0);
        chk("event_q_drained", 32'(exp_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
